// File: rtl/sram_xpose_ctrl.sv
// Frame sequencer for the 4x4 transpose SRAM array: writes a frame row-wise
// (one long row, three short rows), then reads it back column-wise.
module sram_xpose_ctrl #(
  parameter int unsigned AddrLWidth = 7,
  parameter int unsigned AddrSWidth = 5,
  parameter int unsigned RdLat      = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [1:0]              wr_row_o,
  output logic [3:0]              wr_en_l_o,
  output logic [11:0]             wr_en_s_o,
  output logic [4*AddrLWidth-1:0] addr_l_wr_o,
  output logic [12*AddrSWidth-1:0] addr_s_wr_o,
  output logic [3:0]              rd_en_l_o,
  output logic [11:0]             rd_en_s_o,
  output logic [4*AddrLWidth-1:0] addr_l_rd_o,
  output logic [12*AddrSWidth-1:0] addr_s_rd_o,
  output logic [1:0]              rd_col_o,
  output logic                    out_valid_o,
  output logic [3:0]              out_lane_vld_o,
  output logic                    out_last_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [2:0] {IDLE, WR_LONG, WR_SHORT, RD, DRAIN} state_t;

  localparam logic [AddrLWidth-1:0] LastL     = '1;
  localparam logic [AddrLWidth-1:0] LastS     = AddrLWidth'((1 << AddrSWidth) - 1);
  localparam logic [2:0]            LastDrain = 3'(RdLat - 1);

  state_t                r_state, w_next;
  logic [AddrLWidth-1:0] r_wr_cnt, r_rd_cnt;
  logic [1:0]            r_row, r_col;
  logic [2:0]            r_drain;
  logic                  r_done;
  logic                  w_ready, w_accept, w_rd_en, w_rd_short, w_rd_last;

  logic                  r_vld_sr  [RdLat];
  logic [3:0]            r_lane_sr [RdLat];
  logic [1:0]            r_col_sr  [RdLat];
  logic                  r_last_sr [RdLat];

  assign w_ready    = (r_state == WR_LONG) || (r_state == WR_SHORT);
  assign w_accept   = in_valid_i & w_ready;
  assign w_rd_en    = (r_state == RD);
  assign w_rd_short = (r_rd_cnt >> AddrSWidth) == '0;
  assign w_rd_last  = w_rd_en && (r_col == 2'd3) && (r_rd_cnt == LastL);

  assign in_ready_o     = w_ready;
  assign busy_o         = (r_state != IDLE);
  assign done_o         = r_done;
  assign out_valid_o    = r_vld_sr[RdLat-1];
  assign out_lane_vld_o = r_lane_sr[RdLat-1];
  assign rd_col_o       = r_col_sr[RdLat-1];
  assign out_last_o     = r_last_sr[RdLat-1];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start_i) w_next = WR_LONG;
      WR_LONG:  if (w_accept && r_wr_cnt == LastL) w_next = WR_SHORT;
      WR_SHORT: if (w_accept && r_wr_cnt == LastS && r_row == 2'd3) w_next = RD;
      RD:       if (w_rd_last) w_next = DRAIN;
      DRAIN:    if (r_drain == LastDrain) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Write/read/drain counters; counters hold across input bubbles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_drain  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wr_cnt <= '0;
          r_rd_cnt <= '0;
          r_row    <= '0;
          r_col    <= '0;
          r_drain  <= '0;
        end
        WR_LONG: if (w_accept) begin
          if (r_wr_cnt == LastL) begin
            r_wr_cnt <= '0;
            r_row    <= 2'd1;
          end else begin
            r_wr_cnt <= r_wr_cnt + AddrLWidth'(1);
          end
        end
        WR_SHORT: if (w_accept) begin
          if (r_wr_cnt == LastS) begin
            r_wr_cnt <= '0;
            r_row    <= r_row + 2'd1;
          end else begin
            r_wr_cnt <= r_wr_cnt + AddrLWidth'(1);
          end
        end
        RD: begin
          r_rd_cnt <= r_rd_cnt + AddrLWidth'(1);
          if (r_rd_cnt == LastL) r_col <= r_col + 2'd1;
        end
        DRAIN:   r_drain <= r_drain + 3'd1;
        default: ;
      endcase
    end
  end

  // Write-side enables and addresses; only the active row is driven
  always_comb begin
    wr_row_o    = '0;
    wr_en_l_o   = '0;
    wr_en_s_o   = '0;
    addr_l_wr_o = '0;
    addr_s_wr_o = '0;
    case (r_state)
      WR_LONG: begin
        wr_en_l_o = {4{w_accept}};
        for (int unsigned b = 0; b < 4; b++)
          addr_l_wr_o[b*AddrLWidth +: AddrLWidth] = r_wr_cnt;
      end
      WR_SHORT: begin
        wr_row_o = r_row;
        for (int unsigned b = 0; b < 12; b++) begin
          if (r_row == 2'(b / 4 + 1)) begin
            wr_en_s_o[b] = w_accept;
            addr_s_wr_o[b*AddrSWidth +: AddrSWidth] = r_wr_cnt[AddrSWidth-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Read-side enables and addresses for the current column
  always_comb begin
    rd_en_l_o   = '0;
    rd_en_s_o   = '0;
    addr_l_rd_o = '0;
    addr_s_rd_o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (w_rd_en && r_col == 2'(c)) begin
        rd_en_l_o[c] = 1'b1;
        addr_l_rd_o[c*AddrLWidth +: AddrLWidth] = r_rd_cnt;
        if (w_rd_short) begin
          for (int unsigned r = 0; r < 3; r++) begin
            rd_en_s_o[r*4+c] = 1'b1;
            addr_s_rd_o[(r*4+c)*AddrSWidth +: AddrSWidth] = r_rd_cnt[AddrSWidth-1:0];
          end
        end
      end
    end
  end

  // Delay line aligning read-side status with SRAM output data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RdLat; i++) begin
        r_vld_sr[i]  <= 1'b0;
        r_lane_sr[i] <= '0;
        r_col_sr[i]  <= '0;
        r_last_sr[i] <= 1'b0;
      end
    end else begin
      r_vld_sr[0]  <= w_rd_en;
      r_lane_sr[0] <= w_rd_en ? {{3{w_rd_short}}, 1'b1} : 4'b0000;
      r_col_sr[0]  <= w_rd_en ? r_col : 2'd0;
      r_last_sr[0] <= w_rd_last;
      for (int unsigned i = 1; i < RdLat; i++) begin
        r_vld_sr[i]  <= r_vld_sr[i-1];
        r_lane_sr[i] <= r_lane_sr[i-1];
        r_col_sr[i]  <= r_col_sr[i-1];
        r_last_sr[i] <= r_last_sr[i-1];
      end
    end
  end

  // Frame-done pulse coincides with the return to IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_done <= 1'b0;
    else         r_done <= (r_state == DRAIN) && (r_drain == LastDrain);
  end

endmodule

// File: doc/sram_xpose_ctrl.md
Name: sram_xpose_ctrl

Overview:
- Sequences the 4x4 SRAM bank array of the FFT pipeline for one frame.
- Bank layout:
  - Row 0 is four long banks (2**AddrLWidth deep), one per column c0..c3.
  - Rows 1..3 are twelve short banks (2**AddrSWidth deep). Short bank index = (row-1)*4 + col.
- The frame is written row-wise from a 4-lane input stream, then read back column-wise (transpose) to feed the next butterfly stage.
- The block drives enables, addresses and steering selects only; the data paths are muxed outside using wr_row_o and rd_col_o.

Parameters:
- AddrLWidth, 7: long bank address width; long depth LD = 2**AddrLWidth.
- AddrSWidth, 5: short bank address width; short depth SD = 2**AddrSWidth. Must be <= AddrLWidth.
- RdLat, 1: SRAM read latency in cycles, 1..4.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  frame start pulse; honoured only in IDLE.
- in_valid_i  in  1  input beat valid (4 samples).
- in_ready_o  out  1  beat accepted when in_valid_i & in_ready_o.
- wr_row_o  out  2  row receiving write data (data steering select).
- wr_en_l_o  out  4  long bank write enables.
- wr_en_s_o  out  12  short bank write enables.
- addr_l_wr_o  out  4*AddrLWidth  long write addresses.
- addr_s_wr_o  out  12*AddrSWidth  short write addresses.
- rd_en_l_o  out  4  long bank read enables.
- rd_en_s_o  out  12  short bank read enables.
- addr_l_rd_o  out  4*AddrLWidth  long read addresses.
- addr_s_rd_o  out  12*AddrSWidth  short read addresses.
- rd_col_o  out  2  column being read, aligned to data (delayed RdLat).
- out_valid_o  out  1  read data valid, RdLat after rd_en.
- out_lane_vld_o  out  4  per-row lane valid, aligned with out_valid_o.
- out_last_o  out  1  final read beat of the frame, aligned with out_valid_o.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at end of frame.

Behaviour:

Reset:
- All outputs are 0 while rst_ni is low; the FSM is in IDLE; counters are 0.
- Asserting reset mid-frame aborts immediately (asynchronous). There is no resume; the next frame needs a new start_i.

FSM states: IDLE -> WR_LONG -> WR_SHORT -> RD -> DRAIN -> IDLE.
- IDLE: in_ready_o=0. start_i moves to WR_LONG with wr_cnt=0. start_i in any other state is ignored.
- WR_LONG: in_ready_o=1, wr_row_o=0.
  - On accept: wr_en_l_o=4'hF (combinational from the accept), all four addr_l_wr = wr_cnt, wr_cnt++.
  - After beat LD-1: go to WR_SHORT with row=1, wr_cnt=0.
- WR_SHORT: in_ready_o=1, wr_row_o=row.
  - On accept: wr_en_s_o = 4'hF << 4*(row-1), the addresses of those four banks = wr_cnt.
  - After beat SD-1: row++. After row 3 completes, go to RD with col=0, rd_cnt=0.
- RD: rd_en asserted every cycle; there is no output backpressure.
  - rd_en_l_o[col]=1 with addr_l_rd[col]=rd_cnt.
  - rd_en_s_o bits col, col+4, col+8 = 1 only while rd_cnt<SD, with addresses = rd_cnt[AddrSWidth-1:0].
  - rd_cnt wraps at LD-1, then col++. After col 3 / rd_cnt LD-1, go to DRAIN.
- DRAIN: RdLat cycles with no rd_en. Then go to IDLE and pulse done_o in the same cycle as the IDLE entry, i.e. the cycle after the last out_valid_o.

Output rules:
- Zeroing: every address and enable of a bank not accessed in a cycle is driven 0. This includes write and read enables/addresses outside WR_* and RD respectively.
- Input bubbles (in_valid_i=0): no write enable, counters hold, addresses hold their last value on the active row.
- Read-side alignment:
  - out_valid_o, out_lane_vld_o, rd_col_o and out_last_o are rd_en, lane mask, col and the final-read flag delayed through an RdLat-deep shift register.
  - Lane mask = {rd_cnt<SD, rd_cnt<SD, rd_cnt<SD, 1} (bit 0 = row 0).
- Counts: total write beats LD+3*SD (224 at defaults); total read cycles 4*LD (512 at defaults).
- busy_o is high from the cycle after start_i until done_o. done_o is never high while busy_o is high.

Test Plan:
1. Reset check: hold rst_ni low, drive start_i and in_valid_i -> all outputs 0. Release reset -> IDLE, in_ready_o=0, busy_o=0.
2. Gapless write, defaults: start_i then 224 valid beats. Check:
   - beats 0..127: wr_en_l_o=4'hF, addr 0..127.
   - beat 128: wr_en_s_o=12'h00F, addr 0, wr_row_o=1.
   - beat 160: 12'h0F0, wr_row_o=2.
   - beat 192: 12'hF00, wr_row_o=3.
   - after beat 223: in_ready_o=0.
3. Column read: check:
   - col0, rd_cnt=0: rd_en_l_o=4'h1, rd_en_s_o=12'h111.
   - rd_cnt=32: rd_en_s_o=0, lane mask 4'b0001.
   - col1 start: rd_en_l_o=4'h2, rd_en_s_o=12'h222.
   - exactly 512 out_valid_o, out_last_o on the 512th, done_o pulse the next cycle.
4. Bubbles: toggle in_valid_i 1/0 through the write phase -> wr_en only on accepted beats, addresses strictly sequential with no skips, 224 accepts total.
5. Busy and abort: start_i pulses mid-write are ignored (counts unchanged). Assert rst_ni low at read cycle 200 -> outputs 0 immediately; after release a new frame completes normally.
6. RdLat=3 build: out_valid_o rises exactly 3 cycles after the first rd_en. DRAIN lasts 3 cycles, and out_last_o and rd_col_o=3 are aligned.
